// File: rtl/serial_bit_tx_if.sv
// serial_bit_tx_if: handshake and serial-stream bundle between stimulus logic and serial_bit_tx
//   master: drives load/data_in, observes ready/x_out/valid_out/done/busy
//   slave : the transmitter side of the same signals
interface serial_bit_tx_if #(parameter int WIDTH = 8);
    logic             load;
    logic [WIDTH-1:0] data_in;
    logic             ready;
    logic             x_out;
    logic             valid_out;
    logic             done;
    logic             busy;
    modport master (output load, data_in, input ready, x_out, valid_out, done, busy);
    modport slave  (input load, data_in, output ready, x_out, valid_out, done, busy);
endinterface

// File: rtl/serial_bit_tx.sv
// serial_bit_tx: parallel-load, MSB-first serial transmitter feeding a sequence detector's x_in
//   clock : rising-edge clock
//   reset : asynchronous, active-low reset
//   bus   : serial_bit_tx_if.slave (load, data_in in; ready, x_out, valid_out, done, busy out)
//   Optional macro SERIAL_TX_PARITY_EN appends an even-parity bit after the data bits.
module serial_bit_tx #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 5
) (
    input logic            clock,
    input logic            reset,
    serial_bit_tx_if.slave bus
);
`ifdef SERIAL_TX_PARITY_EN
    typedef enum logic [1:0] {IDLE, SHIFT, PARITY, DONE} state_t;
    logic par;
`else
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
`endif
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH);
    state_t           state;
    logic [WIDTH-1:0] sreg;
    logic [CNT_W-1:0] cnt;
    logic             x, v, dn, rdy;
    assign bus.x_out     = x;
    assign bus.valid_out = v;
    assign bus.done      = dn;
    assign bus.ready     = rdy;
    assign bus.busy      = ~rdy;
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            sreg  <= '0;
            cnt   <= '0;
            x     <= 1'b0;
            v     <= 1'b0;
            dn    <= 1'b0;
            rdy   <= 1'b1;
`ifdef SERIAL_TX_PARITY_EN
            par   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (bus.load) begin
                    // first bit goes straight to x_out on the accepting edge
                    sreg  <= bus.data_in;
                    cnt   <= CNT_W'(1);
                    x     <= bus.data_in[WIDTH-1];
                    v     <= 1'b1;
                    rdy   <= 1'b0;
                    state <= SHIFT;
`ifdef SERIAL_TX_PARITY_EN
                    par   <= ^bus.data_in;
`endif
                end
                SHIFT: if (cnt < LAST) begin
                    // sreg[WIDTH-1] is already on x_out, so the next bit is one below it
                    sreg <= sreg << 1;
                    x    <= sreg[WIDTH-2];
                    cnt  <= cnt + CNT_W'(1);
                end else begin
`ifdef SERIAL_TX_PARITY_EN
                    x     <= par;
                    state <= PARITY;
`else
                    x     <= 1'b0;
                    v     <= 1'b0;
                    dn    <= 1'b1;
                    state <= DONE;
`endif
                end
`ifdef SERIAL_TX_PARITY_EN
                PARITY: begin
                    x     <= 1'b0;
                    v     <= 1'b0;
                    dn    <= 1'b1;
                    state <= DONE;
                end
`endif
                DONE: begin
                    dn    <= 1'b0;
                    rdy   <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
